parking_input_conditioner: RTL and testbench

PARKING_INPUT_CONDITIONER -- requirements
Module: parking_input_conditioner

---
 rtl/parking_input_conditioner.sv | 184 ++++++++++++++++++
 tb/tb_parking_input_conditioner.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_input_conditioner.sv
// rtl/parking_input_conditioner.sv - sensor synchronize/debounce and two-digit password entry front end
//
// Ports:
//   clk, reset_n                  system clock (rising edge), asynchronous active-low reset
//   raw_entrance, raw_exit        unsynchronized gate sensors
//   key_valid, key_digit[1:0]     one-cycle keypad digit strobe and value
//   key_clear                     abort/clear strobe
//   sensor_entrance, sensor_exit  debounced sensor levels
//   password_1, password_2        captured digits, exposed only while holding
//   pw_ready                      high while both digits are held
//   timeout                       one-cycle pulse when digit entry times out
//   state[1:0]                    IDLE=0, WAIT_D1=1, WAIT_D2=2, HOLD=3

module parking_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_ready,
    output logic       timeout,
    output logic [1:0] state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        HOLD    = 2'd3
    } state_t;

    logic [1:0]      ent_sync;
    logic [1:0]      exit_sync;
    logic [DB_W-1:0] ent_cnt;
    logic [DB_W-1:0] exit_cnt;
    logic            ent_q;
    logic            exit_q;
    logic            ent_rise;
    logic            exit_rise;

    state_t          cur_state;
    state_t          nxt_state;
    logic [1:0]      digit_1;
    logic [1:0]      digit_2;
    logic [1:0]      digit_1_nxt;
    logic [1:0]      digit_2_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            timeout_nxt;

    // Synchronizers and debouncers. The counter counts consecutive cycles
    // where the synchronized level disagrees with the output; the flip happens
    // on the edge that would take it to DEBOUNCE_CYCLES, so the counter never
    // actually holds that value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_sync        <= 2'b00;
            exit_sync       <= 2'b00;
            ent_cnt         <= '0;
            exit_cnt        <= '0;
            sensor_entrance <= 1'b0;
            sensor_exit     <= 1'b0;
            ent_q           <= 1'b0;
            exit_q          <= 1'b0;
        end else begin
            ent_sync  <= {ent_sync[0], raw_entrance};
            exit_sync <= {exit_sync[0], raw_exit};
            ent_q     <= sensor_entrance;
            exit_q    <= sensor_exit;

            if (ent_sync[1] != sensor_entrance) begin
                if (ent_cnt == DB_LAST) begin
                    sensor_entrance <= ent_sync[1];
                    ent_cnt         <= '0;
                end else begin
                    ent_cnt <= ent_cnt + 1'b1;
                end
            end else begin
                ent_cnt <= '0;
            end

            if (exit_sync[1] != sensor_exit) begin
                if (exit_cnt == DB_LAST) begin
                    sensor_exit <= exit_sync[1];
                    exit_cnt    <= '0;
                end else begin
                    exit_cnt <= exit_cnt + 1'b1;
                end
            end else begin
                exit_cnt <= '0;
            end
        end
    end

    assign ent_rise  = sensor_entrance & ~ent_q;
    assign exit_rise = sensor_exit & ~exit_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            digit_1   <= 2'b00;
            digit_2   <= 2'b00;
            to_cnt    <= '0;
            timeout   <= 1'b0;
            pw_ready  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            digit_1   <= digit_1_nxt;
            digit_2   <= digit_2_nxt;
            to_cnt    <= to_cnt_nxt;
            timeout   <= timeout_nxt;
            pw_ready  <= (nxt_state == HOLD);
        end
    end

    // Abort (clear or exit) beats a digit, and a digit beats the timeout.
    always_comb begin
        nxt_state   = cur_state;
        digit_1_nxt = digit_1;
        digit_2_nxt = digit_2;
        to_cnt_nxt  = to_cnt;
        timeout_nxt = 1'b0;

        case (cur_state)
            IDLE: begin
                if (ent_rise) begin
                    nxt_state = WAIT_D1;
                end
            end
            WAIT_D1, WAIT_D2: begin
                if (key_clear || exit_rise) begin
                    nxt_state = IDLE;
                end else if (key_valid) begin
                    to_cnt_nxt = '0;
                    if (cur_state == WAIT_D1) begin
                        digit_1_nxt = key_digit;
                        nxt_state   = WAIT_D2;
                    end else begin
                        digit_2_nxt = key_digit;
                        nxt_state   = HOLD;
                    end
                end else if (to_cnt == TO_LAST) begin
                    nxt_state   = IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (key_clear || exit_rise) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // Idle keeps the counter at zero so WAIT_D1 always starts fresh.
        if (nxt_state == IDLE) begin
            digit_1_nxt = 2'b00;
            digit_2_nxt = 2'b00;
            to_cnt_nxt  = '0;
        end
    end

    // Digits stay hidden until the full password is held.
    assign password_1 = (cur_state == HOLD) ? digit_1 : 2'b00;
    assign password_2 = (cur_state == HOLD) ? digit_2 : 2'b00;
    assign state      = cur_state;

endmodule

// File: tb/tb_parking_input_conditioner.sv
// tb/tb_parking_input_conditioner.sv - self-checking bench for parking_input_conditioner

module tb_parking_input_conditioner;

    localparam int DEB = 4;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       raw_entrance = 1'b0;
    logic       raw_exit = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_digit = 2'b00;
    logic       key_clear = 1'b0;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pw_ready;
    logic       timeout;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] h_raw_e, h_raw_x, h_syn_e, h_syn_x;
    logic        m_se, m_sx, m_se_d, m_sx_d, m_tmo;
    logic [1:0]  m_st, m_d1, m_d2;
    int          m_idle;

    always #5 clk = ~clk;

    parking_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .raw_entrance   (raw_entrance),
        .raw_exit       (raw_exit),
        .key_valid      (key_valid),
        .key_digit      (key_digit),
        .key_clear      (key_clear),
        .sensor_entrance(sensor_entrance),
        .sensor_exit    (sensor_exit),
        .password_1     (password_1),
        .password_2     (password_2),
        .pw_ready       (pw_ready),
        .timeout        (timeout),
        .state          (state)
    );

    task automatic model_reset();
        h_raw_e = '0; h_raw_x = '0; h_syn_e = '0; h_syn_x = '0;
        m_se = 0; m_sx = 0; m_se_d = 0; m_sx_d = 0; m_tmo = 0;
        m_st = 0; m_d1 = 0; m_d2 = 0; m_idle = 0;
    endtask

    // One rising edge of the reference: a raw level reaches the comparison two
    // edges later, and a sensor flips once DEB consecutive compared samples
    // all disagree with it. The FSM sees a sensor rise one edge after it happens.
    task automatic model_edge();
        logic rise_e, rise_x;
        rise_e = m_se & ~m_se_d;
        rise_x = m_sx & ~m_sx_d;
        m_se_d = m_se;
        m_sx_d = m_sx;
        h_raw_e = {h_raw_e[14:0], raw_entrance};
        h_raw_x = {h_raw_x[14:0], raw_exit};
        h_syn_e = {h_syn_e[14:0], h_raw_e[2]};
        h_syn_x = {h_syn_x[14:0], h_raw_x[2]};
        if (h_syn_e[DEB-1:0] == {DEB{~m_se}}) m_se = ~m_se;
        if (h_syn_x[DEB-1:0] == {DEB{~m_sx}}) m_sx = ~m_sx;

        m_tmo = 0;
        case (m_st)
            2'd0: begin
                if (rise_e) begin m_st = 2'd1; m_idle = 0; end
            end
            2'd1, 2'd2: begin
                if (key_clear || rise_x) begin
                    m_st = 2'd0;
                end else if (key_valid) begin
                    if (m_st == 2'd1) m_d1 = key_digit;
                    else              m_d2 = key_digit;
                    m_st   = m_st + 2'd1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin m_st = 2'd0; m_tmo = 1; end
                end
            end
            default: begin
                if (key_clear || rise_x) m_st = 2'd0;
            end
        endcase
        if (m_st == 2'd0) begin m_d1 = 0; m_d2 = 0; end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state} !== 10'd0)
            begin errors++; $display("FAIL reset_outputs got %b exp 0",
                {sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state}); end
        reset_n = 1;
    endtask

    task automatic test_debounce();
        int n;
        raw_entrance = 1;
        repeat (3) step();
        raw_entrance = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (sensor_entrance !== 1'b0) begin errors++; $display("FAIL glitch_reject cyc %0d got %b exp 0", i, sensor_entrance); end
        end
        raw_entrance = 1;
        n = -1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (n < 0 && sensor_entrance === 1'b1) n = i;
        end
        checks++;
        if (n != DEB + 2) begin errors++; $display("FAIL debounce_latency got %0d exp %0d", n, DEB + 2); end
        raw_entrance = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({sensor_entrance, state, timeout} !== {m_se, m_st, m_tmo})
                begin errors++; $display("FAIL debounce_follow cyc %0d got %b exp %b", i, {sensor_entrance, state, timeout}, {m_se, m_st, m_tmo}); end
        end
    endtask

    task automatic test_entry();
        raw_entrance = 1;
        repeat (8) step();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL entry_wait_d1 got %0d exp 1", state); end
        key_valid = 1; key_digit = 2'b01;
        step();
        checks++;
        if (password_1 !== 2'b00) begin errors++; $display("FAIL entry_no_partial got %b exp 00", password_1); end
        key_digit = 2'b10;
        step();
        key_valid = 0; key_digit = 2'b00;
        checks++;
        if ({state, pw_ready, password_1, password_2} !== {2'd3, 1'b1, 2'b01, 2'b10})
            begin errors++; $display("FAIL entry_hold got %b exp %b", {state, pw_ready, password_1, password_2}, {2'd3, 1'b1, 2'b01, 2'b10}); end
        raw_entrance = 0; raw_exit = 1;
        repeat (8) step();
        checks++;
        if ({state, pw_ready, password_1, password_2} !== 7'd0)
            begin errors++; $display("FAIL entry_exit got %b exp 0", {state, pw_ready, password_1, password_2}); end
        raw_exit = 0;
        repeat (8) step();
    endtask

    task automatic test_timeout();
        int pulses, waits;
        pulses = 0; waits = 0;
        raw_entrance = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (state === 2'd1) waits++;
            if (timeout === 1'b1) begin
                pulses++;
                checks++;
                if ({state, pw_ready} !== 3'd0) begin errors++; $display("FAIL timeout_state got %b exp 0", {state, pw_ready}); end
            end
            checks++;
            if (timeout !== m_tmo) begin errors++; $display("FAIL timeout_pulse cyc %0d got %b exp %b", i, timeout, m_tmo); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", pulses); end
        checks++;
        if (waits != TMO) begin errors++; $display("FAIL timeout_wait_len got %0d exp %0d", waits, TMO); end
        raw_entrance = 0;
        repeat (10) step();
    endtask

    task automatic test_coincidence();
        raw_entrance = 1;
        repeat (8) step();
        raw_entrance = 0;
        key_valid = 1; key_digit = 2'b11;
        step();
        key_clear = 1; key_digit = 2'b01;
        step();
        key_valid = 0; key_clear = 0;
        checks++;
        if ({state, pw_ready, password_2} !== 5'd0)
            begin errors++; $display("FAIL clear_beats_key got %b exp 0", {state, pw_ready, password_2}); end
        repeat (8) step();

        raw_entrance = 1;
        repeat (8) step();
        raw_entrance = 0;
        key_valid = 1; key_digit = 2'b10;
        step();
        key_valid = 0;
        repeat (TMO - 1) step();
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL pre_timeout_state got %0d exp 2", state); end
        key_valid = 1; key_digit = 2'b01;
        step();
        key_valid = 0;
        checks++;
        if ({state, timeout, password_1, password_2} !== {2'd3, 1'b0, 2'b10, 2'b01})
            begin errors++; $display("FAIL key_beats_timeout got %b exp %b", {state, timeout, password_1, password_2}, {2'd3, 1'b0, 2'b10, 2'b01}); end
        key_clear = 1;
        step();
        key_clear = 0;
        checks++;
        if ({state, pw_ready} !== 3'd0) begin errors++; $display("FAIL hold_clear got %b exp 0", {state, pw_ready}); end
    endtask

    task automatic test_midreset();
        int n;
        raw_entrance = 1;
        repeat (8) step();
        key_valid = 1; key_digit = 2'b01;
        step();
        key_valid = 0;
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL midreset_pre got %0d exp 2", state); end
        #2 reset_n = 0;
        #1;
        checks++;
        if ({sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state} !== 10'd0)
            begin errors++; $display("FAIL midreset_async got %b exp 0",
                {sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state}); end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (state !== 2'd0) begin errors++; $display("FAIL midreset_release got %0d exp 0", state); end
            end
            if (n < 0 && sensor_entrance === 1'b1) n = i;
        end
        checks++;
        if (n != DEB + 2) begin errors++; $display("FAIL midreset_redebounce got %0d exp %0d", n, DEB + 2); end
        raw_entrance = 0;
        repeat (10) step();
    endtask

    task automatic test_random();
        logic [1:0] e_p1, e_p2;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) raw_entrance = ~raw_entrance;
            if ($urandom_range(0, 11) == 0) raw_exit = ~raw_exit;
            key_valid = ($urandom_range(0, 3) == 0);
            key_digit = 2'($urandom_range(0, 3));
            key_clear = ($urandom_range(0, 39) == 0);
            step();
            e_p1 = (m_st == 2'd3) ? m_d1 : 2'b00;
            e_p2 = (m_st == 2'd3) ? m_d2 : 2'b00;
            checks++;
            if ({sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state} !==
                {m_se, m_sx, e_p1, e_p2, (m_st == 2'd3), m_tmo, m_st})
                begin errors++; $display("FAIL random cyc %0d got %b exp %b", i,
                    {sensor_entrance, sensor_exit, password_1, password_2, pw_ready, timeout, state},
                    {m_se, m_sx, e_p1, e_p2, (m_st == 2'd3), m_tmo, m_st}); end
        end
        key_valid = 0; key_clear = 0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_entry();
        test_timeout();
        test_coincidence();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
